pkt_tx: RTL and testbench



---
 rtl/pkt_tx_if.sv | 27 ++
 rtl/pkt_tx.sv | 136 +++++++++++++
 tb/tb_pkt_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_tx_if.sv
// Host-side bundle for the packet transmitter:
// buffer load, send request, stall input and flit output.
interface pkt_tx_if #(
  parameter int PKTW = 9
);
  logic            we;
  logic [7:0]      wdata;
  logic            req;
  logic [3:0]      dst;
  logic [3:0]      len;
  logic            full;
  logic [PKTW:0]   dout;
  logic            busy;
  logic            done;
  logic            err;
  logic [3:0]      count;

  modport master (
    output we, wdata, req, dst, len, full,
    input  dout, busy, done, err, count
  );

  modport slave (
    input  we, wdata, req, dst, len, full,
    output dout, busy, done, err, count
  );
endinterface

// File: rtl/pkt_tx.sv
// Packet transmitter: buffers payload bytes, then emits
// head / body / tail flits toward one switch input port.
module pkt_tx #(
  parameter int         PKTW  = 9,
  parameter logic [3:0] SRCID = 4'h0,
  parameter int         DEPTH = 8
) (
  input logic   clk,
  input logic   rst,
  pkt_tx_if.slave bus
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] DEPTH4 = 4'(DEPTH);

  typedef logic [PKTW:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    TAIL
  } state_t;

  state_t     state_q, state_d;
  flit_t      dout_q, dout_d;
  logic [3:0] dst_q, dst_d;
  logic [3:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] count_q, count_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       wr_en;
  logic [3:0] last_d;

  logic [7:0] buf_q [DEPTH];

  assign last_d = len_d - 4'd1;

  // Payload storage; contents only matter below count_q.
  always_ff @(posedge clk) begin
    if (wr_en)
      buf_q[AW'(count_q)] <= bus.wdata;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state; the flit is built from the next state so
  // that dout is a clean register holding the current flit.
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    dout_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.we && count_q != DEPTH4) begin
          wr_en   = 1'b1;
          count_d = count_q + 4'd1;
        end
        // Validation sees the pre-write count.
        if (bus.req) begin
          if (bus.len == 4'd0 || bus.len > count_q) begin
            err_d = 1'b1;
          end else begin
            state_d = HEAD;
            dst_d   = bus.dst;
            len_d   = bus.len;
            idx_d   = 4'd0;
          end
        end
      end
      HEAD: begin
        if (!bus.full)
          state_d = (len_q > 4'd1) ? BODY : TAIL;
      end
      BODY: begin
        if (!bus.full) begin
          idx_d = idx_q + 4'd1;
          if (idx_d == len_q - 4'd1)
            state_d = TAIL;
        end
      end
      TAIL: begin
        if (!bus.full) begin
          done_d  = 1'b1;
          count_d = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      IDLE:    dout_d = '0;
      HEAD:    dout_d = flit_t'({2'b10, SRCID, dst_d});
      BODY:    dout_d = flit_t'({2'b01, buf_q[AW'(idx_d)]});
      TAIL:    dout_d = flit_t'({2'b11, buf_q[AW'(last_d)]});
      default: dout_d = '0;
    endcase
  end

  assign bus.dout  = dout_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Scoreboard bench for pkt_tx: packets are modelled as
// byte lists, expected flits queued, a monitor pops them.
module tb_pkt_tx;

  localparam int         PKTW  = 9;
  localparam logic [3:0] SRCID = 4'h0;
  localparam int         DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pkt_tx_if #(.PKTW(PKTW)) bus ();

  pkt_tx #(
    .PKTW (PKTW),
    .SRCID(SRCID),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [9:0] expq [$];
  logic [7:0] mbuf [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A flit transfers on an edge where dout != 0 and full = 0.
  initial begin : monitor
    logic [9:0] prev;
    bit         hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (hold)
        chk("stall_hold", bus.dout, prev);
      if (!rst && bus.dout != 0 && !bus.full) begin
        if (expq.size() == 0)
          chk("unexpected_flit", bus.dout, 0);
        else
          chk("flit", bus.dout, expq.pop_front());
      end
      hold = (!rst && bus.dout != 0 && bus.full);
      prev = bus.dout;
    end
  end

  task automatic wr(input logic [7:0] b);
    bus.we    = 1'b1;
    bus.wdata = b;
    tick();
    bus.we = 1'b0;
    if (mbuf.size() < DEPTH)
      mbuf.push_back(b);
  endtask

  task automatic push_pkt(input logic [3:0] d,
                          input int l);
    expq.push_back({2'b10, SRCID, d});
    for (int i = 0; i < l - 1; i++)
      expq.push_back({2'b01, mbuf[i]});
    expq.push_back({2'b11, mbuf[l-1]});
  endtask

  task automatic send(input logic [3:0] d,
                      input logic [3:0] l,
                      input bit stall,
                      input bit wr_too);
    int pre;
    bit ok;
    bit seen;
    int cyc;
    int stalls;
    pre  = mbuf.size();
    ok   = (l != 0 && int'(l) <= pre);
    seen = 1'b0;
    cyc  = 0;
    stalls = 0;
    bus.req = 1'b1;
    bus.dst = d;
    bus.len = l;
    if (wr_too) begin
      bus.we    = 1'b1;
      bus.wdata = 8'($urandom);
    end
    if (ok)
      push_pkt(d, int'(l));
    tick();
    bus.req = 1'b0;
    bus.we  = 1'b0;
    if (wr_too && pre < DEPTH)
      mbuf.push_back(bus.wdata);
    chk("err", bus.err, 32'(!ok));
    if (!ok) begin
      chk("rej_dout", bus.dout, 0);
      chk("rej_count", bus.count, mbuf.size());
      return;
    end
    chk("busy", bus.busy, 1);
    while (cyc < 300 && !seen) begin
      bus.full  = stall && ($urandom_range(0, 2) == 0);
      bus.we    = 1'($urandom_range(0, 1));
      bus.wdata = 8'($urandom);
      if (bus.full)
        stalls++;
      tick();
      cyc++;
      seen = bus.done;
      if (!seen)
        chk("busy_count", bus.count, mbuf.size());
    end
    bus.full = 1'b0;
    bus.we   = 1'b0;
    chk("done_seen", 32'(seen), 1);
    if (seen) begin
      chk("flit_cycles", cyc, int'(l) + 1 + stalls);
      chk("idle_dout", bus.dout, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_count", bus.count, 0);
      chk("sb_empty", expq.size(), 0);
    end
    mbuf.delete();
    expq.delete();
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nw;
    int l;
    bus.we    = 1'b0;
    bus.wdata = '0;
    bus.req   = 1'b0;
    bus.dst   = '0;
    bus.len   = '0;
    bus.full  = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    chk("rst_dout", bus.dout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_count", bus.count, 0);
    rst = 1'b0;
    tick();

    wr(8'h00); wr(8'h01); wr(8'h02);
    send(4'd0, 4'd3, 1'b0, 1'b0);

    wr(8'h0F);
    send(4'd2, 4'd1, 1'b0, 1'b0);

    wr(8'h00); wr(8'h01); wr(8'h02);
    send(4'd0, 4'd3, 1'b1, 1'b0);

    wr(8'hA1); wr(8'hB2); wr(8'hC3);
    send(4'd1, 4'd0, 1'b0, 1'b0);
    send(4'd1, 4'd5, 1'b0, 1'b0);
    chk("count3", bus.count, 3);
    for (int i = 0; i < 6; i++)
      wr(8'(8'h40 + i));
    chk("count_sat", bus.count, DEPTH);
    send(4'd3, 4'd8, 1'b1, 1'b0);

    wr(8'h55); wr(8'h66);
    send(4'd1, 4'd2, 1'b0, 1'b1);

    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    bus.req = 1'b1;
    bus.dst = 4'd3;
    bus.len = 4'd4;
    push_pkt(4'd3, 4);
    tick();
    bus.req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_count", bus.count, 0);
    rst = 1'b0;
    expq.delete();
    mbuf.delete();
    tick();

    wr(8'h9C);
    send(4'd2, 4'd1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      nw = $urandom_range(0, 10);
      for (int i = 0; i < nw; i++)
        wr(8'($urandom));
      l = $urandom_range(0, mbuf.size() + 1);
      send(4'($urandom), 4'(l),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
